history_trace_dump: RTL and testbench
=====================================

HISTORY_TRACE_DUMP -- requirements
Module: history_trace_dump

Interface
REQ-001 WIDTH, 8, bit width of each history entry.
REQ-002 DEPTH, 16, number of history entries; SHALL be >= 2.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, synchronous and active-high.
REQ-005 history_in  input  WIDTH x [0:DEPTH-1]  history array from the upstream signal-history stage; entry 0 is newest.
REQ-006 trigger  input  1  request a dump of history_in, sampled every cycle.
REQ-007 out_ready  input  1  downstream ready for the current beat.
REQ-008 out_valid  output  1  out_data/out_index/out_last are valid.
REQ-009 out_data  output  WIDTH  current beat payload.
REQ-010 out_index  output  $clog2(DEPTH)  history index of the current beat.
REQ-011 out_last  output  1  high on the final beat of a dump.
REQ-012 busy  output  1  high while a dump is in progress.
REQ-013 trig_dropped  output  1  one-cycle pulse when a trigger is ignored because busy.

Function
REQ-014 FSM states are IDLE and STREAM, plus CHECK when the configuration macro is defined.
REQ-015 In IDLE with trigger=1, the block SHALL copy all DEPTH entries of history_in into an internal snapshot on that edge, clear the beat counter, and enter STREAM.
REQ-016 Latency: out_valid SHALL rise on the cycle after the triggering edge, with entry 0.
REQ-017 Beats SHALL be emitted in index order 0..DEPTH-1; out_data equals snapshot[out_index].
REQ-018 A beat transfers only on a cycle where out_valid=1 and out_ready=1; the counter then advances by 1.
REQ-019 While out_valid=1 and out_ready=0, out_data, out_index and out_last SHALL hold unchanged.
REQ-020 Changes on history_in after the capture edge SHALL NOT affect the dump in progress.
REQ-021 busy SHALL equal (state != IDLE); out_valid SHALL equal busy.
REQ-022 A trigger while busy, including on the final-beat transfer cycle, SHALL be ignored and SHALL pulse trig_dropped for exactly that cycle.
REQ-023 After the final beat transfers, the FSM SHALL return to IDLE on the next edge; back-to-back dumps therefore need a trigger in IDLE.
REQ-024 Without back-pressure, a dump occupies exactly DEPTH cycles of out_valid (DEPTH+1 with the macro).
REQ-025 The counter SHALL NOT wrap; out_index never exceeds DEPTH-1.

Reset
REQ-026 While rst=1 at an edge: state=IDLE, counter=0, out_valid=0, out_last=0, busy=0, trig_dropped=0, out_index=0, out_data=0, snapshot cleared to 0.
REQ-027 rst SHALL take priority over trigger and handshake on the same edge.
REQ-028 Reset mid-dump SHALL abandon the dump; no remaining beat is emitted after reset releases.

Configuration
REQ-029 Macro HISTORY_DUMP_CHECKSUM_EN, when defined, SHALL add state CHECK entered after beat DEPTH-1 transfers, emitting one extra beat with out_data = XOR of all snapshot entries and out_index = 0.
REQ-030 With HISTORY_DUMP_CHECKSUM_EN defined, out_last SHALL be high only on the checksum beat; without it, out_last SHALL be high on beat DEPTH-1 and CHECK SHALL NOT exist.

Verification (WIDTH=8, DEPTH=4)
REQ-031 history_in={0x11,0x22,0x33,0x44}, trigger one cycle, out_ready=1 -> beats 0x11,0x22,0x33,0x44 on four consecutive cycles, index 0..3, out_last on 0x44, busy low afterwards.
REQ-032 Same stimulus, out_ready=0 for 3 cycles during beat 1 -> out_data holds 0x22 with index 1 for those cycles; order is otherwise unchanged.
REQ-033 history_in changed to all 0xFF on the cycle after trigger -> stream still outputs 0x11..0x44.
REQ-034 trigger pulsed during beat 2 -> trig_dropped high for one cycle; the dump is unaffected; no second dump follows.
REQ-035 rst asserted at beat 1 for one cycle -> out_valid=0, busy=0 after the edge, and no beats until a new trigger.
REQ-036 HISTORY_DUMP_CHECKSUM_EN defined, REQ-031 stimulus -> fifth beat 0x44 (0x11^0x22^0x33^0x44) with out_last=1; beat 0x44 at index 3 has out_last=0.

Source files
------------

// File: rtl/history_trace_dump_if.sv
// rtl/history_trace_dump_if.sv - stream output bundle for the history trace dump
interface history_trace_dump_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
);
    localparam int IDXW = $clog2(DEPTH);

    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_data;
    logic [IDXW-1:0]  out_index;
    logic             out_last;

    modport master (
        output out_valid,
        output out_data,
        output out_index,
        output out_last,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_index,
        input  out_last,
        output out_ready
    );
endinterface

// File: rtl/history_trace_dump.sv
// rtl/history_trace_dump.sv - snapshot a history array on trigger and stream it out (optional HISTORY_DUMP_CHECKSUM_EN)
module history_trace_dump #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [WIDTH-1:0]     history_in [0:DEPTH-1],
    input  logic                 trigger,
    history_trace_dump_if.master out_if,
    output logic                 busy,
    output logic                 trig_dropped
);
    localparam int IDXW = $clog2(DEPTH);
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(DEPTH - 1);

`ifdef HISTORY_DUMP_CHECKSUM_EN
    typedef enum logic [1:0] {S_IDLE, S_STREAM, S_CHECK} state_t;
`else
    typedef enum logic [0:0] {S_IDLE, S_STREAM} state_t;
`endif

    state_t           state_q, state_d;
    logic [IDXW-1:0]  cnt_q, cnt_d;
    logic [WIDTH-1:0] snap_q [0:DEPTH-1];
    logic             capture;

    logic             valid_o;
    logic [WIDTH-1:0] data_o;
    logic [IDXW-1:0]  index_o;
    logic             last_o;

`ifdef HISTORY_DUMP_CHECKSUM_EN
    logic [WIDTH-1:0] checksum;

    // XOR-fold of the frozen snapshot, emitted as the trailing beat
    always_comb begin
        checksum = '0;
        for (int i = 0; i < DEPTH; i++) begin
            checksum = checksum ^ snap_q[i];
        end
    end
`endif

    // State and beat counter registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Snapshot is frozen at the trigger edge so later history changes cannot leak in
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= '0;
            end
        end else if (capture) begin
            for (int i = 0; i < DEPTH; i++) begin
                snap_q[i] <= history_in[i];
            end
        end
    end

    // Next-state, counter and stream outputs; payload is zeroed whenever no beat is offered
    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        capture      = 1'b0;
        valid_o      = 1'b0;
        data_o       = '0;
        index_o      = '0;
        last_o       = 1'b0;
        busy         = 1'b0;
        trig_dropped = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (trigger) begin
                    capture = 1'b1;
                    cnt_d   = '0;
                    state_d = S_STREAM;
                end
            end
            S_STREAM: begin
                busy         = 1'b1;
                valid_o      = 1'b1;
                data_o       = snap_q[cnt_q];
                index_o      = cnt_q;
                trig_dropped = trigger;
`ifndef HISTORY_DUMP_CHECKSUM_EN
                last_o       = (cnt_q == LAST_IDX);
`endif
                if (out_if.out_ready) begin
                    if (cnt_q == LAST_IDX) begin
                        cnt_d = '0;
`ifdef HISTORY_DUMP_CHECKSUM_EN
                        state_d = S_CHECK;
`else
                        state_d = S_IDLE;
`endif
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
`ifdef HISTORY_DUMP_CHECKSUM_EN
            S_CHECK: begin
                busy         = 1'b1;
                valid_o      = 1'b1;
                data_o       = checksum;
                index_o      = '0;
                last_o       = 1'b1;
                trig_dropped = trigger;
                if (out_if.out_ready) begin
                    state_d = S_IDLE;
                end
            end
`endif
            default: begin
                state_d = S_IDLE;
            end
        endcase
        if (rst) begin
            trig_dropped = 1'b0;
        end
    end

    assign out_if.out_valid = valid_o;
    assign out_if.out_data  = data_o;
    assign out_if.out_index = index_o;
    assign out_if.out_last  = last_o;
endmodule

// File: tb/tb_history_trace_dump.sv
// tb/tb_history_trace_dump.sv - randomized self-checking bench for history_trace_dump
module tb_history_trace_dump;
    localparam int W = 8;
    localparam int D = 4;
`ifdef HISTORY_DUMP_CHECKSUM_EN
    localparam bit CK = 1'b1;
`else
    localparam bit CK = 1'b0;
`endif

    typedef struct {
        logic [W-1:0] d;
        logic [1:0]   i;
        logic         l;
    } beat_t;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [W-1:0] hist [0:D-1];
    logic         trigger = 1'b0;
    logic         busy;
    logic         trig_dropped;
    int           n_checks = 0;
    int           n_fail = 0;
    int           cyc = 0;
    beat_t        exp_q [$];

    history_trace_dump_if #(.WIDTH(W), .DEPTH(D)) out_if ();

    history_trace_dump #(.WIDTH(W), .DEPTH(D)) dut (
        .clk          (clk),
        .rst          (rst),
        .history_in   (hist),
        .trigger      (trigger),
        .out_if       (out_if),
        .busy         (busy),
        .trig_dropped (trig_dropped)
    );

    always #5 clk = ~clk;

    function automatic logic [13:0] exp_vec();
        logic  v;
        beat_t b;
        v   = (exp_q.size() > 0);
        b.d = '0;
        b.i = '0;
        b.l = 1'b0;
        if (v) b = exp_q[0];
        return {v, b.d, b.i, b.l, v, trigger & v & ~rst};
    endfunction

    function automatic logic [13:0] act_vec();
        return {out_if.out_valid, out_if.out_data, out_if.out_index, out_if.out_last, busy, trig_dropped};
    endfunction

    // advance the reference model with the inputs applied this cycle, then clock
    task automatic tick();
        beat_t        b;
        logic [W-1:0] x;
        if (rst) begin
            exp_q.delete();
        end else if (exp_q.size() > 0) begin
            if (out_if.out_ready) void'(exp_q.pop_front());
        end else if (trigger) begin
            x = '0;
            for (int i = 0; i < D; i++) begin
                b.d = hist[i];
                b.i = 2'(i);
                b.l = (i == D - 1) && !CK;
                exp_q.push_back(b);
                x = x ^ hist[i];
            end
            if (CK) begin
                b.d = x;
                b.i = '0;
                b.l = 1'b1;
                exp_q.push_back(b);
            end
        end
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic set_hist_const();
        hist[0] = 8'h11; hist[1] = 8'h22; hist[2] = 8'h33; hist[3] = 8'h44;
    endtask

    task automatic test_reset();
        rst = 1'b1; trigger = 1'b1; out_if.out_ready = 1'b0;
        for (int i = 0; i < D; i++) hist[i] = 8'($urandom);
        tick(); tick();
        @(negedge clk);
        n_checks++;
        if (act_vec() !== 14'h0) begin
            n_fail++;
            $display("FAIL reset: got %h expected %h", act_vec(), 14'h0);
        end
        trigger = 1'b0;
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic test_basic();
        int nvalid = 0;
        set_hist_const();
        out_if.out_ready = 1'b1;
        trigger = 1'b1;
        for (int c = 0; c < 9; c++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL basic cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (out_if.out_valid === 1'b1) nvalid++;
            tick();
            trigger = 1'b0;
        end
        n_checks++;
        if (nvalid != D + (CK ? 1 : 0)) begin
            n_fail++;
            $display("FAIL basic_len: got %0d expected %0d", nvalid, D + (CK ? 1 : 0));
        end
    endtask

    task automatic test_backpressure();
        int stalls = 0;
        set_hist_const();
        trigger = 1'b1;
        for (int c = 0; c < 12; c++) begin
            out_if.out_ready = 1'b1;
            if (exp_q.size() > 0 && exp_q[0].i == 2'd1 && stalls < 3) begin
                out_if.out_ready = 1'b0;
                stalls++;
            end
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL backpressure cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            tick();
            trigger = 1'b0;
        end
        out_if.out_ready = 1'b1;
    endtask

    task automatic test_capture();
        set_hist_const();
        trigger = 1'b1;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL capture cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            tick();
            trigger = 1'b0;
            for (int i = 0; i < D; i++) hist[i] = 8'hFF;
        end
        n_checks++;
        if (out_if.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL capture_idle: got %b expected 0", out_if.out_valid);
        end
    endtask

    task automatic test_trig_dropped();
        int  drops = 0;
        bit  fired = 0;
        set_hist_const();
        trigger = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL trig_dropped cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            if (trig_dropped === 1'b1) drops++;
            tick();
            trigger = 1'b0;
            if (!fired && exp_q.size() > 0 && exp_q[0].i == 2'd2 && !exp_q[0].l) begin
                trigger = 1'b1;
                fired = 1;
            end
        end
        n_checks++;
        if (drops != 1) begin
            n_fail++;
            $display("FAIL drop_count: got %0d expected 1", drops);
        end
    endtask

    task automatic test_reset_mid();
        set_hist_const();
        trigger = 1'b1;
        tick();
        trigger = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            n_checks++;
            if (act_vec() !== 14'h0 || exp_q.size() != 0) begin
                n_fail++;
                $display("FAIL reset_mid cycle %0d: got %h expected %h", c, act_vec(), 14'h0);
            end
            tick();
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 400; c++) begin
            for (int i = 0; i < D; i++) hist[i] = 8'($urandom);
            trigger          = ($urandom_range(0, 5) == 0);
            out_if.out_ready = ($urandom_range(0, 9) < 7);
            rst              = ($urandom_range(0, 99) == 0);
            @(negedge clk);
            n_checks++;
            if (act_vec() !== exp_vec()) begin
                n_fail++;
                $display("FAIL random cycle %0d: got %h expected %h", c, act_vec(), exp_vec());
            end
            tick();
        end
        rst = 1'b0;
        trigger = 1'b0;
        out_if.out_ready = 1'b1;
        for (int c = 0; c < 8; c++) tick();
    endtask

    initial begin
        out_if.out_ready = 1'b0;
        for (int i = 0; i < D; i++) hist[i] = '0;
        test_reset();
        test_basic();
        test_backpressure();
        test_capture();
        test_trig_dropped();
        test_reset_mid();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
